// File: rtl/i2s_pkg.sv
// Shared constants, types and helpers for the I2S frame transmitter.
// Sample and slot widths are fixed here for the whole audio path; the
// divider ratio and mono/stereo selection stay per-instance parameters.
package i2s_pkg;

  localparam int SAMPLE_WIDTH  = 16;
  localparam int SLOT_WIDTH    = 32;
  localparam int DEF_BCLK_DIV  = 4;
  localparam int FRAME_BITS    = 2 * SLOT_WIDTH;
  localparam int LEFT_MSB_IDX  = 0;
  localparam int RIGHT_MSB_IDX = SLOT_WIDTH;
  localparam int BIT_IDX_W     = $clog2(FRAME_BITS);
  localparam int SAMPLE_IDX_W  = $clog2(SAMPLE_WIDTH);

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [BIT_IDX_W-1:0]           bit_idx_t;

  // Bit of sample s that belongs at frame position b for a slot whose MSB
  // sits at msb_idx; positions outside the sample are padded with zero.
  function automatic logic slot_bit(input sample_t s, input bit_idx_t b,
                                    input int msb_idx);
    int off;
    off = int'(b) - msb_idx;
    if (off >= 0 && off < SAMPLE_WIDTH)
      return s[SAMPLE_IDX_W'(SAMPLE_WIDTH - 1 - off)];
    return 1'b0;
  endfunction

  // Word select for frame position b: high from one bit before the right
  // MSB up to one bit before the frame wraps (Philips one-bit lead).
  function automatic logic lrclk_level(input bit_idx_t b);
    return (int'(b) >= SLOT_WIDTH - 1) && (int'(b) <= FRAME_BITS - 2);
  endfunction

endpackage

// File: rtl/i2s_bclk_div.sv
// Bit-clock divider: free-running count of clk cycles per BCLK period,
// registered bclk, and strobes that flag the edge on which bclk falls
// (count wraps to 0) or rises.
module i2s_bclk_div #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bclk,
  output logic fall,
  output logic rise
);

  localparam int CNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BCLK_DIV / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count and event strobes; strobes mark the clk edge that ends this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_nxt = cnt + 1'b1;
    if (cnt == CNT_LAST) cnt_nxt = '0;
    fall = en && (cnt == CNT_LAST);
    rise = en && (cnt == CNT_HALF - 1'b1);
  end

  // Count and bit clock; disable parks both at their reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      bclk <= (cnt_nxt >= CNT_HALF);
    end
  end

endmodule

// File: rtl/i2s_frame_tx.sv
// I2S master transmitter: one-deep sample holding register behind a
// valid/ready handshake, frame sequencing on BCLK fall events, and an
// underrun counter for frames that had to replay the previous sample.
module i2s_frame_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = DEF_BCLK_DIV,
  parameter bit MONO     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  sample_t     s_data_l,
  input  sample_t     s_data_r,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        frame_start,
  output logic        bclk,
  output logic        lrclk,
  output logic        dacdat,
  output logic [7:0]  underrun_cnt
);

  localparam bit_idx_t LAST_IDX = bit_idx_t'(FRAME_BITS - 1);

  logic     fall;
  logic     rise;
  bit_idx_t b;
  bit_idx_t b_nxt;
  sample_t  hold_l, hold_r, last_l, last_r;
  sample_t  src_l, src_r;
  logic     hold_full, hold_full_nxt;
  logic     xfer, load, bit_nxt;

  i2s_bclk_div #(.BCLK_DIV(BCLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bclk  (bclk),
    .fall  (fall),
    .rise  (rise)
  );

  // Rise and fall events are half a BCLK apart and never coincide.
  a_rise_fall_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(rise && fall));

  // Handshake, frame-load decision and the serial bit for the next BCLK period.
  always_comb begin
    xfer  = s_valid && s_ready;
    load  = fall && (b == LAST_IDX);
    b_nxt = (b == LAST_IDX) ? '0 : b + 1'b1;
    // A frame load takes the holding register if full, else replays the last pair.
    src_l = (load && hold_full) ? hold_l : last_l;
    src_r = (load && hold_full) ? hold_r : last_r;
    // Load empties holding first; a same-edge transfer refills it, never bypasses.
    hold_full_nxt = hold_full;
    if (load) hold_full_nxt = 1'b0;
    if (xfer) hold_full_nxt = 1'b1;
    bit_nxt = slot_bit(src_l, b_nxt, LEFT_MSB_IDX) | slot_bit(src_r, b_nxt, RIGHT_MSB_IDX);
  end

  // Holding/last-sample registers, frame sequencing and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sample registers are reset too, so an underrun before any data replays silence.
      hold_l       <= '0;
      hold_r       <= '0;
      last_l       <= '0;
      last_r       <= '0;
      hold_full    <= 1'b0;
      s_ready      <= 1'b1;
      b            <= LAST_IDX;
      lrclk        <= 1'b0;
      dacdat       <= 1'b0;
      frame_start  <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      hold_full   <= hold_full_nxt;
      s_ready     <= !hold_full_nxt;
      frame_start <= 1'b0;
      if (xfer) begin
        hold_l <= s_data_l;
        hold_r <= (MONO != 1'b0) ? s_data_l : s_data_r;
      end
      if (!en) begin
        b      <= LAST_IDX;
        lrclk  <= 1'b0;
        dacdat <= 1'b0;
      end else if (fall) begin
        b      <= b_nxt;
        lrclk  <= lrclk_level(b_nxt);
        dacdat <= bit_nxt;
        if (load) begin
          frame_start <= 1'b1;
          last_l      <= src_l;
          last_r      <= src_r;
          if (!hold_full && underrun_cnt != 8'hFF)
            underrun_cnt <= underrun_cnt + 8'd1;
        end
      end
    end
  end

endmodule
